cnn_frame_loader: RTL and testbench
===================================

// Module: cnn_frame_loader
// PURPOSE
//  Upstream feeder for the cnn core. Accepts one input frame as a valid/ready word stream and writes it into the
//  IF1 BRAM through the core's 32-bit BRAM port. It then pulses start with the latched mode and waits for done.
//  Finally it presents the 8-bit inference result on a valid/ready output. This replaces the preloaded-memory flow.
// PARAMETERS
//  N_WORDS     1024   words per frame (one 32-bit activation per word, 32x32 input)
//  ADDR_STRIDE 4      byte-address increment per word on BRAM_IF1_ADDR
//  TIMEOUT     200000 cycles allowed between start pulse and done (used only with LOADER_TIMEOUT_EN)
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous, active-high reset
//  s_valid        in   1   input word valid
//  s_ready        out  1   loader can accept a word
//  s_data         in   32  activation word
//  s_mode         in   1   model select (1 number, 0 letter); sampled on the first beat of a frame
//  BRAM_IF1_ADDR  out  32  byte address to IF1 BRAM
//  BRAM_IF1_EN    out  1   BRAM enable
//  BRAM_IF1_WE    out  4   byte write enables
//  BRAM_IF1_DIN   out  32  write data
//  cnn_start      out  1   one-cycle start pulse to cnn
//  cnn_mode       out  1   mode held to cnn for the whole run
//  cnn_done       in   1   cnn finished
//  cnn_result     in   8   cnn class index, valid while cnn_done=1
//  m_valid        out  1   result valid
//  m_ready        in   1   result consumed
//  m_result       out  8   captured class index
//  busy           out  1   high in any state except IDLE
//  timeout        out  1   sticky abort flag (LOADER_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0; word count=0; cnn_mode=0. A run in progress is dropped.
//  FSM: IDLE -> LOAD on first s_valid. LOAD -> START after word N_WORDS-1 is written. START -> WAIT (1 cycle).
//       WAIT -> OUT on cnn_done. OUT -> IDLE on m_valid&&m_ready.
//  s_ready=1 only in IDLE/LOAD. A beat is accepted when s_valid&&s_ready. The first accepted beat latches s_mode into cnn_mode.
//  Write: the beat accepted in cycle t drives EN=1, WE=4'hF, DIN=s_data, ADDR=idx*ADDR_STRIDE, all registered at cycle t+1.
//    Outside a write cycle EN=0 and WE=0. Addresses run 0,4,...,4*(N_WORDS-1). The counter never wraps within a frame.
//  s_ready drops in the cycle after the last beat is accepted. Extra words are back-pressured, not written.
//  cnn_start: exactly one cycle, asserted in START. This is the cycle after the last BRAM write, so the final write
//    completes before start.
//  cnn_done is ignored outside WAIT. In WAIT, the first done cycle captures cnn_result into m_result and sets m_valid.
//  m_valid/m_result stay stable until m_ready. m_ready while m_valid=0 has no effect.
//  A new frame may begin in the cycle after OUT -> IDLE. Gaps in s_valid stall LOAD indefinitely, with no timeout.
//  cnn_mode changes only on the first beat of a frame.
// CONFIGURATION
//  LOADER_TIMEOUT_EN defined:
//    - A cycle counter runs in WAIT. At TIMEOUT cycles without done: go to IDLE, set timeout=1 (sticky until rst),
//      and raise no m_valid.
//    - Any later cnn_done is ignored.
//  LOADER_TIMEOUT_EN undefined: no counter, timeout tied 0, WAIT holds until done.
// STRUCTURE
//  Shared package cnn_pkg:
//    - loader state encoding (IDLE, LOAD, START, WAIT, OUT)
//    - MODE_NUMBER=1, MODE_LETTER=0
//    - N_WORDS default and ADDR_STRIDE constants
//  Single module. The watchdog lives inline under the macro; no sub-module is warranted.
// TESTING
//  1 Reset idle: rst pulse -> all outputs 0, s_ready=0 until out of reset, busy=0.
//  2 Full frame, mode=1, s_valid always high:
//    - 1024 writes at addr 0..0xFFC with WE=4'hF
//    - cnn_start high exactly 1 cycle after the write to 0xFFC; cnn_mode=1
//    - model done with result=7 after 50 cycles -> m_valid=1, m_result=7
//  3 Back-pressure both sides:
//    - random s_valid gaps -> written data matches the stream in order
//    - hold m_ready=0 for 20 cycles -> m_result stable; s_ready=0 throughout
//  4 Spurious done: cnn_done pulse during LOAD -> ignored, no m_valid. Second frame with mode=0 -> cnn_mode=0, result 25 returned.
//  5 Mid-run reset: assert rst at word 500 -> outputs 0 immediately. A new frame restarts at addr 0.
//  6 LOADER_TIMEOUT_EN with TIMEOUT=100 and done never asserted -> timeout=1 at cycle 100 after start, busy=0, m_valid=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the cnn core and its frame loader: loader state encoding,
// model-select values and frame geometry.
package cnn_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  localparam logic MODE_NUMBER = 1'b1;
  localparam logic MODE_LETTER = 1'b0;

  localparam int N_WORDS_DEF     = 1024;
  localparam int ADDR_STRIDE_DEF = 4;

  // Byte address of activation word idx in the IF1 BRAM.
  function automatic logic [31:0] word_addr(input int unsigned idx, input int unsigned stride);
    return 32'(idx * stride);
  endfunction

endpackage

// File: rtl/cnn_frame_loader.sv
// Streams one input frame into the IF1 BRAM, kicks the cnn core and returns its class index.
// Optional watchdog on the cnn run: define LOADER_TIMEOUT_EN.
module cnn_frame_loader
  import cnn_pkg::*;
#(
  parameter int N_WORDS     = N_WORDS_DEF,
  parameter int ADDR_STRIDE = ADDR_STRIDE_DEF
`ifdef LOADER_TIMEOUT_EN
  , parameter int TIMEOUT   = 200000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_mode,
  output logic [31:0] BRAM_IF1_ADDR,
  output logic        BRAM_IF1_EN,
  output logic [3:0]  BRAM_IF1_WE,
  output logic [31:0] BRAM_IF1_DIN,
  output logic        cnn_start,
  output logic        cnn_mode,
  input  logic        cnn_done,
  input  logic [7:0]  cnn_result,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_result,
  output logic        busy,
  output logic        timeout
);

  localparam int CNT_W = $clog2(N_WORDS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_WORDS);

  logic [2:0]       state;
  logic [CNT_W-1:0] word_cnt;
  logic             ready_en;
  logic             frame_full;
  logic             accept;
  logic             wd_expire;

  // ready_en keeps s_ready low while rst is held, even though state already reads IDLE.
  assign frame_full = (word_cnt == FULL_CNT);
  assign s_ready    = ready_en && ((state == ST_IDLE) || ((state == ST_LOAD) && !frame_full));
  assign accept     = s_valid && s_ready;
  assign busy       = (state != ST_IDLE);
  assign cnn_start  = (state == ST_START);

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      word_cnt      <= '0;
      ready_en      <= 1'b0;
      cnn_mode      <= MODE_LETTER;
      m_valid       <= 1'b0;
      m_result      <= '0;
      BRAM_IF1_ADDR <= '0;
      BRAM_IF1_EN   <= 1'b0;
      BRAM_IF1_WE   <= '0;
      BRAM_IF1_DIN  <= '0;
    end else begin
      ready_en    <= 1'b1;
      BRAM_IF1_EN <= accept;
      BRAM_IF1_WE <= accept ? 4'hF : 4'h0;
      if (accept) begin
        BRAM_IF1_ADDR <= word_addr(int'(word_cnt), ADDR_STRIDE);
        BRAM_IF1_DIN  <= s_data;
        word_cnt      <= word_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnn_mode <= s_mode;
            state    <= ST_LOAD;
          end
        end
        // The final word is written during the cycle spent here with frame_full set,
        // so START follows the last BRAM write.
        ST_LOAD: begin
          if (frame_full) begin
            word_cnt <= '0;
            state    <= ST_START;
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (cnn_done) begin
            m_result <= cnn_result;
            m_valid  <= 1'b1;
            state    <= ST_OUT;
          end else if (wd_expire) begin
            state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // wd_cnt equals the number of cycles since the start pulse, so the abort
  // becomes visible exactly TIMEOUT cycles after start.
  assign wd_expire = (state == ST_WAIT) && !cnn_done && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign timeout   = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_START) begin
        wd_cnt <= WD_W'(1);
      end else if (state == ST_WAIT) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Self-checking bench for cnn_frame_loader: table-driven frames with a BRAM write
// scoreboard and result scoreboard, plus reset, mid-run reset and watchdog sequences.
module tb_cnn_frame_loader;
  import cnn_pkg::*;

  localparam int NW     = 1024;
  localparam int STRIDE = 4;
`ifdef LOADER_TIMEOUT_EN
  localparam int TO     = 100;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_mode;
  logic [31:0] BRAM_IF1_ADDR;
  logic        BRAM_IF1_EN;
  logic [3:0]  BRAM_IF1_WE;
  logic [31:0] BRAM_IF1_DIN;
  logic        cnn_start;
  logic        cnn_mode;
  logic        cnn_done;
  logic [7:0]  cnn_result;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_result;
  logic        busy;
  logic        timeout;

  cnn_frame_loader #(
    .N_WORDS    (NW),
    .ADDR_STRIDE(STRIDE)
`ifdef LOADER_TIMEOUT_EN
    , .TIMEOUT  (TO)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_mode       (s_mode),
    .BRAM_IF1_ADDR(BRAM_IF1_ADDR),
    .BRAM_IF1_EN  (BRAM_IF1_EN),
    .BRAM_IF1_WE  (BRAM_IF1_WE),
    .BRAM_IF1_DIN (BRAM_IF1_DIN),
    .cnn_start    (cnn_start),
    .cnn_mode     (cnn_mode),
    .cnn_done     (cnn_done),
    .cnn_result   (cnn_result),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_result     (m_result),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic       mode;
    int         gap_pct;
    int         spur_at;
    int         done_delay;
    int         hold;
    logic [7:0] result;
  } vec_t;

  wr_t        wr_q[$];
  logic [7:0] res_q[$];
  vec_t       vecs[3];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // BRAM write monitor: every write must match the next word the bench handed over.
  always @(negedge clk) begin
    if (!rst) begin
      if (BRAM_IF1_EN) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing pending", BRAM_IF1_ADDR, BRAM_IF1_DIN);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("bram_addr", BRAM_IF1_ADDR, e.addr);
          check("bram_din", BRAM_IF1_DIN, e.data);
          check("bram_we", 32'(BRAM_IF1_WE), 32'hF);
        end
      end else begin
        check("bram_we_idle", 32'(BRAM_IF1_WE), 32'h0);
      end
    end
  end

  // Drives words 0..stop_at-1 with random gaps; pushes each accepted word to the scoreboard.
  task automatic send_frame(input logic mode, input int gap_pct, input int spur_at, input int stop_at);
    int   i = 0;
    int   budget = 0;
    logic saw_mvalid = 1'b0;
    logic [31:0] d;
    while (i < stop_at) begin
      s_valid    = ($urandom_range(99) >= gap_pct);
      d          = $urandom;
      s_data     = d;
      s_mode     = (i == 0) ? mode : ~mode;
      cnn_done   = (i == spur_at);
      cnn_result = 8'($urandom);
      m_ready    = 1'($urandom);
      @(negedge clk);
      if (m_valid) saw_mvalid = 1'b1;
      if (s_valid && s_ready) begin
        wr_q.push_back('{addr: 32'(i * STRIDE), data: d});
        i++;
      end
      budget++;
      if (budget > 8 * NW) begin
        checks++;
        failures++;
        $display("FAIL load_stalled: accepted %0d of %0d words", i, stop_at);
        break;
      end
      step();
    end
    cnn_done = 1'b0;
    m_ready  = 1'b0;
    check("no_mvalid_in_load", 32'(saw_mvalid), 32'h0);
  endtask

  // Full frame: last-write/start timing, done model, output back-pressure and handshake.
  task automatic run_vector(input vec_t v);
    logic [7:0] exp_res;
    send_frame(v.mode, v.gap_pct, v.spur_at, NW);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("s_ready_after_last", 32'(s_ready), 32'h0);
    check("last_write_en", 32'(BRAM_IF1_EN), 32'h1);
    check("last_write_addr", BRAM_IF1_ADDR, 32'((NW - 1) * STRIDE));
    check("start_before_last", 32'(cnn_start), 32'h0);
    step();
    @(negedge clk);
    check("start_pulse", 32'(cnn_start), 32'h1);
    check("cnn_mode", 32'(cnn_mode), 32'(v.mode));
    check("busy_in_start", 32'(busy), 32'h1);
    step();
    @(negedge clk);
    check("start_one_cycle", 32'(cnn_start), 32'h0);
    for (int k = 0; k < v.done_delay; k++) step();
    cnn_done   = 1'b1;
    cnn_result = v.result;
    res_q.push_back(v.result);
    step();
    cnn_done   = 1'b0;
    cnn_result = 8'($urandom);
    s_valid    = 1'b0;
    @(negedge clk);
    check("m_valid_set", 32'(m_valid), 32'h1);
    exp_res = (res_q.size() != 0) ? res_q.pop_front() : 8'hXX;
    check("m_result", 32'(m_result), 32'(exp_res));
    for (int h = 0; h < v.hold; h++) begin
      step();
      m_ready    = 1'b0;
      cnn_done   = 1'($urandom);
      cnn_result = 8'($urandom);
      s_valid    = 1'($urandom);
      @(negedge clk);
      check("m_valid_held", 32'(m_valid), 32'h1);
      check("m_result_stable", 32'(m_result), 32'(exp_res));
      check("s_ready_in_out", 32'(s_ready), 32'h0);
    end
    step();
    cnn_done = 1'b0;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    step();
    m_ready = 1'b0;
    @(negedge clk);
    check("m_valid_cleared", 32'(m_valid), 32'h0);
    check("busy_after_out", 32'(busy), 32'h0);
    check("s_ready_after_out", 32'(s_ready), 32'h1);
    check("cnn_mode_kept", 32'(cnn_mode), 32'(v.mode));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{mode: MODE_NUMBER, gap_pct: 0,  spur_at: -1,  done_delay: 50, hold: 0,  result: 8'd7};
    vecs[1] = '{mode: MODE_NUMBER, gap_pct: 30, spur_at: -1,  done_delay: 3,  hold: 20, result: 8'hA5};
    vecs[2] = '{mode: MODE_LETTER, gap_pct: 10, spur_at: 200, done_delay: 0,  hold: 2,  result: 8'd25};

    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    s_mode     = 1'b0;
    cnn_done   = 1'b0;
    cnn_result = '0;
    m_ready    = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bram_en", 32'(BRAM_IF1_EN), 32'h0);
    check("rst_bram_addr", BRAM_IF1_ADDR, 32'h0);
    check("rst_bram_din", BRAM_IF1_DIN, 32'h0);
    check("rst_cnn_start", 32'(cnn_start), 32'h0);
    check("rst_cnn_mode", 32'(cnn_mode), 32'h0);
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_result", 32'(m_result), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    step();
    @(negedge clk);
    check("rst_s_ready_held", 32'(s_ready), 32'h0);
    step();
    rst = 1'b0;
    step();
    step();
    @(negedge clk);
    check("s_ready_after_reset", 32'(s_ready), 32'h1);
    check("busy_after_reset", 32'(busy), 32'h0);

    // Mid-run reset at word 500 drops the frame immediately
    step();
    send_frame(MODE_NUMBER, 0, -1, 500);
    rst = 1'b1;
    #1;
    check("midrst_bram_en", 32'(BRAM_IF1_EN), 32'h0);
    check("midrst_bram_addr", BRAM_IF1_ADDR, 32'h0);
    check("midrst_bram_we", 32'(BRAM_IF1_WE), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_s_ready", 32'(s_ready), 32'h0);
    check("midrst_cnn_mode", 32'(cnn_mode), 32'h0);
    wr_q.delete();
    s_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // Table-driven frames; the first also proves the restart at address 0
    for (int n = 0; n < 3; n++) begin
      run_vector(vecs[n]);
      step();
    end

`ifdef LOADER_TIMEOUT_EN
    // Watchdog: done never arrives
    send_frame(MODE_NUMBER, 0, -1, NW);
    s_valid = 1'b0;
    step();
    @(negedge clk);
    check("to_start_pulse", 32'(cnn_start), 32'h1);
    for (int k = 1; k <= TO; k++) begin
      step();
      @(negedge clk);
      if (k == TO - 1) check("to_not_yet", 32'(timeout), 32'h0);
    end
    check("to_flag", 32'(timeout), 32'h1);
    check("to_busy", 32'(busy), 32'h0);
    check("to_m_valid", 32'(m_valid), 32'h0);
    step();
    cnn_done   = 1'b1;
    cnn_result = 8'd99;
    step();
    cnn_done = 1'b0;
    @(negedge clk);
    check("to_late_done_ignored", 32'(m_valid), 32'h0);
    check("to_sticky", 32'(timeout), 32'h1);
`endif

    step();
    check("write_queue_drained", 32'(wr_q.size()), 32'h0);
    check("result_queue_drained", 32'(res_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
